seq_alu: RTL and testbench

- Parametrised, multi-cycle successor to the combinational 20-bit operation circuits.
- One registered ALU with a start/done handshake and an opcode-selected operation: logic, arithmetic with carry-in, compare, and iterative multi-bit shift/rotate.
- Produces a registered result plus carry/zero/sign status flags, consumed by the status register and jump logic.

---
 rtl/seq_alu.sv | 200 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle registered ALU with start/done handshake and iterative shift/rotate.
// Define SEQ_ALU_MUL_EN to make op 15 a shift-add multiply; otherwise op 15 is a NOP.
module seq_alu #(
  parameter int WIDTH   = 20,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign
);

  // state | meaning
  // IDLE  | ready=1, waiting for start
  // SHIFT | one shift/rotate step per edge, cnt counts down to 1
  // MUL   | one shift-add partial product per edge (SEQ_ALU_MUL_EN only)
  // DONE  | done=1 for one cycle, then back to IDLE
`ifdef SEQ_ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_MUL} state_t;
  localparam int MCW   = $clog2(WIDTH + 1);
  localparam int CNT_W = (MCW > SHAMT_W) ? MCW : SHAMT_W;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  localparam int CNT_W = SHAMT_W;
`endif

  localparam logic [3:0] OP_NOT = 4'd0,  OP_AND = 4'd1,  OP_OR  = 4'd2,  OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SUB = 4'd6,  OP_SBB = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8,  OP_DEC = 4'd9,  OP_SHL = 4'd10, OP_SHR = 4'd11;
  localparam logic [3:0] OP_ROL = 4'd12, OP_ROR = 4'd13, OP_CMP = 4'd14, OP_X15 = 4'd15;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc;
  logic [3:0]         sop;

  logic [WIDTH:0]     ea, eb, ec, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_z, alu_s;
  logic [WIDTH-1:0]   sh_nx;
  logic               sh_out;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;

  assign shamt    = b[SHAMT_W-1:0];
  assign is_shift = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);

  // Single-cycle datapath, evaluated straight from the inputs at the accepting edge.
  always_comb begin
    ea      = {1'b0, a};
    eb      = {1'b0, b};
    ec      = {{WIDTH{1'b0}}, cin};
    diff    = ea - eb;
    alu_res = a;
    alu_c   = 1'b0;
    case (op)
      OP_NOT:  alu_res = ~a;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_ADD:  {alu_c, alu_res} = ea + eb;
      OP_ADC:  {alu_c, alu_res} = ea + eb + ec;
      OP_SUB:  {alu_c, alu_res} = ea - eb;
      OP_SBB:  {alu_c, alu_res} = ea - eb - ec;
      OP_INC:  {alu_c, alu_res} = ea + (WIDTH+1)'(1);
      OP_DEC:  {alu_c, alu_res} = ea - (WIDTH+1)'(1);
      OP_CMP:  alu_c = diff[WIDTH];
      default: alu_res = a;
    endcase
    if (op == OP_CMP) begin
      alu_z = (diff[WIDTH-1:0] == '0);
      alu_s = diff[WIDTH-1];
    end else begin
      alu_z = (alu_res == '0);
      alu_s = alu_res[WIDTH-1];
    end
  end

  always_comb begin
    sh_nx  = acc;
    sh_out = 1'b0;
    case (sop)
      OP_SHL:  begin sh_nx = {acc[WIDTH-2:0], 1'b0};         sh_out = acc[WIDTH-1]; end
      OP_SHR:  begin sh_nx = {1'b0, acc[WIDTH-1:1]};         sh_out = acc[0];       end
      OP_ROL:  begin sh_nx = {acc[WIDTH-2:0], acc[WIDTH-1]}; sh_out = acc[WIDTH-1]; end
      OP_ROR:  begin sh_nx = {acc[0], acc[WIDTH-1:1]};       sh_out = acc[0];       end
      default: begin sh_nx = acc;                            sh_out = 1'b0;         end
    endcase
  end

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] ma, mhi, mlo, mhi_nx, mlo_nx;
  logic [WIDTH:0]   msum;

  // Add a into the upper half when the multiplier LSB is set, then shift the pair right.
  always_comb begin
    msum   = {1'b0, mhi} + (mlo[0] ? {1'b0, ma} : '0);
    mhi_nx = msum[WIDTH:1];
    mlo_nx = {msum[0], mlo[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      sign   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      sop    <= OP_NOT;
`ifdef SEQ_ALU_MUL_EN
      ma     <= '0;
      mhi    <= '0;
      mlo    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ready <= 1'b0;
            if (is_shift && (shamt != '0)) begin
              acc   <= a;
              sop   <= op;
              cnt   <= CNT_W'(shamt);
              state <= S_SHIFT;
`ifdef SEQ_ALU_MUL_EN
            end else if (op == OP_X15) begin
              ma    <= a;
              mhi   <= '0;
              mlo   <= b;
              cnt   <= CNT_W'(WIDTH);
              state <= S_MUL;
`endif
            end else begin
              result <= alu_res;
              carry  <= alu_c;
              zero   <= alu_z;
              sign   <= alu_s;
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          if (cnt == CNT_W'(1)) begin
            result <= sh_nx;
            carry  <= sh_out;
            zero   <= (sh_nx == '0);
            sign   <= sh_nx[WIDTH-1];
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            acc <= sh_nx;
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef SEQ_ALU_MUL_EN
        S_MUL: begin
          if (cnt == CNT_W'(1)) begin
            result <= mlo_nx;
            carry  <= (mhi_nx != '0);
            zero   <= (mlo_nx == '0);
            sign   <= mlo_nx[WIDTH-1];
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            mhi <= mhi_nx;
            mlo <= mlo_nx;
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif
        S_DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: expectations come from a behavioural model, compared on done.
module tb_seq_alu;
  localparam int W = 20;
  localparam longint MASK = (longint'(1) << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         ready, done, carry, zero, sign;
  logic [W-1:0] result;

  seq_alu #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .ready(ready), .done(done), .result(result), .carry(carry), .zero(zero), .sign(sign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c, z, s;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] xa, xb, input logic xc);
    exp_t   e;
    longint la = longint'(xa), lb = longint'(xb), t = 0;
    int     n = int'(xb[4:0]);
    int     m = n % W;
    e.lat = 0; e.c = 1'b0;
    case (o)
      4'd0:  t = ~la & MASK;
      4'd1:  t = la & lb;
      4'd2:  t = la | lb;
      4'd3:  t = la ^ lb;
      4'd4:  begin t = la + lb;                 e.c = (t > MASK); end
      4'd5:  begin t = la + lb + longint'(xc);  e.c = (t > MASK); end
      4'd6:  begin t = la - lb;                 e.c = (t < 0);    end
      4'd7:  begin t = la - lb - longint'(xc);  e.c = (t < 0);    end
      4'd8:  begin t = la + 1;                  e.c = (la == MASK); end
      4'd9:  begin t = la - 1;                  e.c = (la == 0);  end
      4'd10: begin t = la << n; e.c = (n != 0) && (((t >> W) & 1) == 1); e.lat = n; end
      4'd11: begin t = la >> n; e.c = (n != 0) && (((la >> (n - 1)) & 1) == 1); e.lat = n; end
      4'd12: begin t = ((la << m) | (la >> (W - m))) & MASK; e.c = (n != 0) && ((t & 1) == 1); e.lat = n; end
      4'd13: begin t = ((la >> m) | (la << (W - m))) & MASK; e.c = (n != 0) && (((t >> (W - 1)) & 1) == 1); e.lat = n; end
      4'd14: t = la;
      default: begin
`ifdef SEQ_ALU_MUL_EN
        t = la * lb; e.c = ((t >> W) != 0); e.lat = W;
`else
        t = la;
`endif
      end
    endcase
    e.res = W'(t & MASK);
    e.z = (e.res == '0);
    e.s = e.res[W-1];
    if (o == 4'd14) begin
      t = (la - lb) & MASK;
      e.z = (la == lb);
      e.s = ((t >> (W - 1)) & 1) == 1;
      e.c = (la < lb);
    end
    return e;
  endfunction

  // Launches one op, optionally pulses a stray start at sample poke_at, and scores on done.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] xa, xb, input logic xc,
                        input int poke_at);
    exp_t e;
    int cyc = 0, rlow = 0, guard = 0;
    exp_q.push_back(model(o, xa, xb, xc));
    while (!ready && guard < 100) begin @(posedge clk); #1; guard++; end
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb; cin = xc;
    @(posedge clk); #1;
    start = 1'b0;
    if (!ready) rlow++;
    while (!done && cyc < 100) begin
      if (cyc == poke_at && poke_at >= 0) begin
        start = 1'b1; op = 4'd4; a = 20'h00001; b = 20'h00001;
      end else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (!ready) rlow++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL timeout op=%0d: no done within %0d cycles", o, cyc);
      return;
    end
    n_vec++;
    if (cyc !== e.lat) begin n_err++; $display("FAIL latency op=%0d: got %0d want %0d", o, cyc, e.lat); end
    n_vec++;
    if (result !== e.res) begin n_err++; $display("FAIL result op=%0d a=%h b=%h: got %h want %h", o, xa, xb, result, e.res); end
    n_vec++;
    if ({carry, zero, sign} !== {e.c, e.z, e.s})
      begin n_err++; $display("FAIL flags op=%0d a=%h b=%h: got c%bz%bs%b want c%bz%bs%b", o, xa, xb, carry, zero, sign, e.c, e.z, e.s); end
    n_vec++;
    if (rlow !== e.lat + 1) begin n_err++; $display("FAIL ready_low op=%0d: got %0d want %0d", o, rlow, e.lat + 1); end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || ready !== 1'b1) begin n_err++; $display("FAIL done_pulse op=%0d: done=%b ready=%b want 0/1", o, done, ready); end
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({ready, done, result, carry, zero, sign} !== {1'b1, 1'b0, 20'h00000, 3'b000})
      begin n_err++; $display("FAIL reset: got r%b d%b %h c%bz%bs%b want r1 d0 00000 c0z0s0", ready, done, result, carry, zero, sign); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    int seen = 0;
    @(negedge clk); start = 1'b1; op = 4'd12; a = 20'h12345; b = 20'd8;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({ready, done, result} !== {1'b1, 1'b0, 20'h00000})
      begin n_err++; $display("FAIL reset_mid: got r%b d%b %h want r1 d0 00000", ready, done, result); end
    @(negedge clk); rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (done) seen++; end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL reset_mid_done: got %0d pulses want 0", seen); end
  endtask

  task automatic test_arith;
    run_op(4'd4,  20'hFFFFF, 20'h00001, 1'b0, -1);
    run_op(4'd5,  20'h00001, 20'h00001, 1'b1, -1);
    run_op(4'd7,  20'h00005, 20'h00005, 1'b1, -1);
    run_op(4'd14, 20'h00003, 20'h00007, 1'b0, -1);
    run_op(4'd14, 20'h00009, 20'h00009, 1'b0, -1);
    run_op(4'd6,  20'h00010, 20'h00003, 1'b0, -1);
    run_op(4'd8,  20'hFFFFF, 20'h00000, 1'b0, -1);
    run_op(4'd9,  20'h00000, 20'h00000, 1'b0, -1);
  endtask

  task automatic test_logic;
    run_op(4'd0, 20'h0F0F0, 20'h00000, 1'b0, -1);
    run_op(4'd1, 20'hABCDE, 20'h0FF00, 1'b0, -1);
    run_op(4'd2, 20'h80000, 20'h00001, 1'b0, -1);
    run_op(4'd3, 20'h5A5A5, 20'h5A5A5, 1'b0, -1);
  endtask

  task automatic test_shift;
    run_op(4'd10, 20'hE0000, 20'd3,  1'b0, -1);
    run_op(4'd11, 20'h00001, 20'd0,  1'b0, -1);
    run_op(4'd10, 20'hFFFFF, 20'd25, 1'b0, -1);
    run_op(4'd11, 20'h80000, 20'd20, 1'b0, -1);
    run_op(4'd12, 20'h80001, 20'd1,  1'b0, -1);
    run_op(4'd12, 20'h00003, 20'd0,  1'b0, -1);
  endtask

  task automatic test_start_ignored;
    run_op(4'd13, 20'h00001, 20'd21, 1'b0, 5);
  endtask

  task automatic test_op15;
    run_op(4'd15, 20'h00400, 20'h00800, 1'b0, -1);
    run_op(4'd15, 20'h00123, 20'h00045, 1'b0, -1);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 24; i++)
      run_op(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 1'($urandom), -1);
  endtask

  initial begin
    test_reset;
    test_arith;
    test_logic;
    test_shift;
    test_start_ignored;
    test_op15;
    test_reset_mid_op;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
